// File: rtl/skin_binarization_lin.sv
// Pipelined linear skin classifier: weighted feature sum plus bias, thresholded.
// Define SKIN_BIN_HYST_EN to add a per-line hysteresis threshold (thr_lo).
module skin_binarization_lin #(
  parameter int N_CH   = 7,
  parameter int FEAT_W = 8,
  parameter int COEF_W = 12,
  parameter int ACC_W  = FEAT_W + COEF_W + 1 + $clog2(N_CH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   de_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic [N_CH*FEAT_W-1:0] feat,
  input  logic                   cfg_we,
  input  logic [4:0]             cfg_addr,
  input  logic [31:0]            cfg_data,
  output logic [7:0]             skin,
  output logic [ACC_W-1:0]       y_out,
  output logic                   de_out,
  output logic                   hsync_out,
  output logic                   vsync_out
);

  localparam int T   = $clog2(N_CH);
  localparam int LAT = 4 + T;
  localparam int PW  = FEAT_W + COEF_W + 1;

  function automatic int lvl_n(input int l);
    int n;
    n = N_CH;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic        [COEF_W-1:0] w_sh_q  [N_CH];
  logic signed [COEF_W-1:0] w_act_q [N_CH];
  logic        [ACC_W-1:0]  bias_sh_q;
  logic        [ACC_W-1:0]  hi_sh_q;
  logic signed [ACC_W-1:0]  bias_act_q;
  logic signed [ACC_W-1:0]  hi_act_q;
`ifdef SKIN_BIN_HYST_EN
  logic        [ACC_W-1:0]  lo_sh_q;
  logic signed [ACC_W-1:0]  lo_act_q;
  logic                     run_q;
  logic                     run_d;
`endif
  logic                     vs_prev_q;
  logic                     commit;

  logic signed [FEAT_W:0]   f_q   [N_CH];
  logic signed [PW-1:0]     p_q   [N_CH];
  logic signed [ACC_W-1:0]  p_ext [N_CH];
  logic signed [ACC_W-1:0]  t_d   [T][N_CH];
  logic signed [ACC_W-1:0]  t_q   [T][N_CH];
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [ACC_W-1:0]  y_q;
  logic        [7:0]        skin_q;
  logic        [7:0]        skin_d;
  logic                     hit;
  logic        [2:0]        sync_q [LAT];
  logic                     unused_cfg;

  assign unused_cfg = ^cfg_data;
  assign commit = ce & vsync_in & ~vs_prev_q;

  // Shadow writes from the register port; shadow copied to active on vsync rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        w_sh_q[i]  <= '0;
        w_act_q[i] <= '0;
      end
      bias_sh_q  <= '0;
      bias_act_q <= '0;
      hi_sh_q    <= '0;
      hi_act_q   <= '0;
`ifdef SKIN_BIN_HYST_EN
      lo_sh_q    <= '0;
      lo_act_q   <= '0;
`endif
      vs_prev_q  <= 1'b0;
    end else begin
      if (ce) vs_prev_q <= vsync_in;
      if (commit) begin
        for (int i = 0; i < N_CH; i++)
          w_act_q[i] <= w_sh_q[i];
        bias_act_q <= bias_sh_q;
        hi_act_q   <= hi_sh_q;
`ifdef SKIN_BIN_HYST_EN
        lo_act_q   <= lo_sh_q;
`endif
      end
      if (cfg_we) begin
        for (int i = 0; i < N_CH; i++)
          if (cfg_addr == 5'(i)) w_sh_q[i] <= cfg_data[COEF_W-1:0];
        if (cfg_addr == 5'(N_CH))   bias_sh_q <= cfg_data[ACC_W-1:0];
        if (cfg_addr == 5'(N_CH+1)) hi_sh_q   <= cfg_data[ACC_W-1:0];
`ifdef SKIN_BIN_HYST_EN
        if (cfg_addr == 5'(N_CH+2)) lo_sh_q   <= cfg_data[ACC_W-1:0];
`endif
      end
    end
  end

  // Feature capture and per-channel signed products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        f_q[i] <= '0;
        p_q[i] <= '0;
      end
    end else if (ce) begin
      for (int i = 0; i < N_CH; i++) begin
        f_q[i] <= {1'b0, feat[i*FEAT_W +: FEAT_W]};
        p_q[i] <= f_q[i] * w_act_q[i];
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ext
    assign p_ext[i] = {{(ACC_W-PW){p_q[i][PW-1]}}, p_q[i]};
  end

  for (genvar l = 0; l < T; l++) begin : g_lvl
    localparam int NIN = lvl_n(l);
    for (genvar i = 0; i < N_CH; i++) begin : g_node
      if (2*i+1 < NIN) begin : g_add
        if (l == 0) begin : g_l0
          assign t_d[l][i] = p_ext[2*i] + p_ext[2*i+1];
        end else begin : g_ln
          assign t_d[l][i] = t_q[l-1][2*i] + t_q[l-1][2*i+1];
        end
      end else if (2*i < NIN) begin : g_pass
        if (l == 0) begin : g_l0
          assign t_d[l][i] = p_ext[2*i];
        end else begin : g_ln
          assign t_d[l][i] = t_q[l-1][2*i];
        end
      end else begin : g_zero
        assign t_d[l][i] = '0;
      end
    end
  end

  // Adder tree levels and bias addition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < T; l++)
        for (int i = 0; i < N_CH; i++)
          t_q[l][i] <= '0;
      sum_q <= '0;
    end else if (ce) begin
      for (int l = 0; l < T; l++)
        for (int i = 0; i < N_CH; i++)
          t_q[l][i] <= t_d[l][i];
      sum_q <= t_q[T-1][0] + bias_act_q;
    end
  end

  // Threshold decision (with optional line-local hysteresis)
  always_comb begin
    hit = sum_q > hi_act_q;
`ifdef SKIN_BIN_HYST_EN
    hit   = hit | (run_q & (sum_q > lo_act_q));
    run_d = sync_q[LAT-2][2] ? hit : 1'b0;
`endif
    skin_d = hit ? 8'hFF : 8'h00;
  end

  // Output stage and sync delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= '0;
      skin_q <= '0;
`ifdef SKIN_BIN_HYST_EN
      run_q  <= 1'b0;
`endif
      for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
    end else if (ce) begin
      y_q    <= sum_q;
      skin_q <= skin_d;
`ifdef SKIN_BIN_HYST_EN
      run_q  <= run_d;
`endif
      sync_q[0] <= {de_in, hsync_in, vsync_in};
      for (int i = 1; i < LAT; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign y_out     = y_q;
  assign skin      = skin_q;
  assign de_out    = sync_q[LAT-1][2];
  assign hsync_out = sync_q[LAT-1][1];
  assign vsync_out = sync_q[LAT-1][0];

endmodule

// File: tb/tb_skin_binarization_lin.sv
// Bench for skin_binarization_lin: random pixels against a frame-level model.
// Expected results are queued at stimulus time and popped when outputs appear.
module tb_skin_binarization_lin;
  localparam int N_CH   = 7;
  localparam int FEAT_W = 8;
  localparam int COEF_W = 12;
  localparam int ACC_W  = 25;
  localparam int LAT    = 7;
  localparam int FW     = N_CH*FEAT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          de_in = 1'b0;
  logic          hsync_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic [FW-1:0] feat = '0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = '0;
  logic [31:0]   cfg_data = '0;
  logic [7:0]    skin;
  logic [ACC_W-1:0] y_out;
  logic          de_out, hsync_out, vsync_out;

  skin_binarization_lin #(
    .N_CH(N_CH), .FEAT_W(FEAT_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .feat(feat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .skin(skin), .y_out(y_out), .de_out(de_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  typedef struct { longint y; bit hit; } exp_t;

  int     n_chk = 0;
  int     n_fail = 0;
  exp_t   exp_q[$];
  logic [2:0] sync_exp[$];

  longint w_sh[N_CH], w_act[N_CH];
  longint bias_sh, bias_act, hi_sh, hi_act, lo_sh, lo_act;
  bit     vs_prev, m_run;

  function automatic longint sx(input longint v, input int w);
    longint m;
    m = longint'(1) << w;
    v = v % m;
    if (v < 0) v += m;
    if (v >= m/2) v -= m;
    return v;
  endfunction

  // Reference model: frame-level register semantics and arithmetic sum
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin w_sh[i] = 0; w_act[i] = 0; end
      bias_sh = 0; bias_act = 0; hi_sh = 0; hi_act = 0;
      lo_sh = 0; lo_act = 0; vs_prev = 0; m_run = 0;
      exp_q.delete();
      sync_exp.delete();
      repeat (LAT-1) sync_exp.push_back(3'b000);
    end else begin
      if (ce) begin
        if (vsync_in && !vs_prev) begin
          w_act = w_sh; bias_act = bias_sh; hi_act = hi_sh; lo_act = lo_sh;
        end
        vs_prev = vsync_in;
        if (de_in) begin
          exp_t e;
          e.y = bias_act;
          for (int i = 0; i < N_CH; i++)
            e.y += w_act[i] * longint'(feat[i*FEAT_W +: FEAT_W]);
          e.hit = e.y > hi_act;
`ifdef SKIN_BIN_HYST_EN
          if (m_run && e.y > lo_act) e.hit = 1'b1;
`endif
          m_run = e.hit;
          exp_q.push_back(e);
        end else begin
          m_run = 0;
        end
        sync_exp.push_back({de_in, hsync_in, vsync_in});
      end
      if (cfg_we) begin
        for (int i = 0; i < N_CH; i++)
          if (int'(cfg_addr) == i) w_sh[i] = sx(longint'(cfg_data), COEF_W);
        if (int'(cfg_addr) == N_CH)   bias_sh = sx(longint'(cfg_data), ACC_W);
        if (int'(cfg_addr) == N_CH+1) hi_sh   = sx(longint'(cfg_data), ACC_W);
`ifdef SKIN_BIN_HYST_EN
        if (int'(cfg_addr) == N_CH+2) lo_sh   = sx(longint'(cfg_data), ACC_W);
`endif
      end
    end
  end

  // Monitor: on every enabled edge check sync outputs, and data when de_out
  always @(posedge clk) begin
    bit ce_s, r_s;
    ce_s = ce;
    r_s  = rst_n;
    #1;
    if (r_s && ce_s) begin
      logic [2:0] s_exp;
      n_chk++;
      if (sync_exp.size() == 0) begin
        n_fail++;
        $display("FAIL sync_queue: got empty, required an entry");
      end else begin
        s_exp = sync_exp.pop_front();
        if ({de_out, hsync_out, vsync_out} !== s_exp) begin
          n_fail++;
          $display("FAIL sync: got %b required %b",
                   {de_out, hsync_out, vsync_out}, s_exp);
        end
      end
      if (de_out === 1'b1) begin
        exp_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL data_queue: got output with no expected pixel");
        end else begin
          e = exp_q.pop_front();
          if (longint'($signed(y_out)) != e.y ||
              skin !== (e.hit ? 8'hFF : 8'h00)) begin
            n_fail++;
            $display("FAIL pixel: got y=%0d skin=%0d required y=%0d skin=%0d",
                     $signed(y_out), skin, e.y, e.hit ? 255 : 0);
          end
        end
      end
    end
  end

  function automatic logic [FW-1:0] rfeat();
    logic [FW-1:0] f;
    for (int i = 0; i < N_CH; i++) f[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
    return f;
  endfunction

  task automatic step(input bit c, input bit d, input bit h, input bit v,
                      input logic [FW-1:0] f, input bit we = 0,
                      input int a = 0, input longint dat = 0);
    @(negedge clk);
    ce = c; de_in = d; hsync_in = h; vsync_in = v; feat = f;
    cfg_we = we; cfg_addr = 5'(a); cfg_data = 32'(dat);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1, 0, 1'($urandom), 0, rfeat());
  endtask

  task automatic wr(input int a, input longint dat);
    step(1, 0, 0, 0, rfeat(), 1, a, dat);
  endtask

  task automatic commit();
    idle(LAT + 1);
    step(1, 0, 0, 1, rfeat());
    idle(LAT + 1);
  endtask

  task automatic pix(input int f0, input int f1 = -1);
    logic [FW-1:0] f;
    f = rfeat();
    if (f0 >= 0) f[0 +: FEAT_W] = FEAT_W'(f0);
    if (f1 >= 0) f[FEAT_W +: FEAT_W] = FEAT_W'(f1);
    step(1, 1, 0, 0, f);
  endtask

  task automatic line(input int n);
    repeat (n) pix(-1);
  endtask

  task automatic cfg_unit(input longint b, input longint hi);
    wr(0, 1);
    for (int i = 1; i < N_CH; i++) wr(i, 0);
    wr(N_CH, b);
    wr(N_CH + 1, hi);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (y_out !== '0 || skin !== 8'h00 || de_out !== 1'b0 ||
        hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got y=%0d skin=%0d sync=%b required all zero",
               y_out, skin, {de_out, hsync_out, vsync_out});
    end
    @(negedge clk);
    rst_n = 1'b1;

    idle(3);
    line(12);
    idle(4);

    cfg_unit(-100, 0);
    wr(31, 32'hDEAD_BEEF);
    commit();
    pix(101); pix(100); pix(99); pix(255); pix(0);
    repeat (8) pix(int'($urandom_range(80, 120)));
    idle(3);

    wr(0, -2048); wr(1, 2047);
    for (int i = 2; i < N_CH; i++) wr(i, 0);
    wr(N_CH, 0); wr(N_CH + 1, 0);
    commit();
    pix(255, 255); pix(0, 255); pix(255, 0); pix(1, 2);
    idle(2);

    for (int i = 0; i < N_CH; i++) wr(i, longint'($urandom));
    wr(N_CH, longint'($urandom_range(0, 1 << 23)) - (1 << 22));
    wr(N_CH + 1, longint'($urandom_range(0, 1 << 21)) - (1 << 20));
    wr(N_CH + 2, longint'($urandom));
    commit();
    line(40);

    cfg_unit(0, 0);
    commit();
    line(5);
    step(1, 1, 0, 0, rfeat(), 1, N_CH, 1000);
    line(10);
    idle(2);
    line(5);
    commit();
    line(8);
    idle(LAT + 1);
    step(1, 0, 0, 1, rfeat(), 1, N_CH, -500);
    idle(LAT + 1);
    line(8);
    commit();
    line(8);

    for (int i = 0; i < N_CH; i++) wr(i, longint'($urandom));
    commit();
    for (int k = 0; k < 32; k++) begin
      logic [FW-1:0] f;
      for (int i = 0; i < N_CH; i++) f[i*FEAT_W +: FEAT_W] = FEAT_W'(k * 8 + i);
      step(1, 1, 0, 0, f);
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), rfeat());
    end
    idle(3);

    cfg_unit(0, 50);
    wr(N_CH + 2, 20);
    commit();
    pix(60); pix(30); pix(30); pix(10); pix(30);
    idle(1);
    pix(30);
    pix(60); pix(30);
    idle(1);
    pix(30);

    idle(LAT + 4);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pixels outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
